// File: rtl/sme_pkg.sv
// Shared types and sizing for the string-matching-engine feeder.
package sme_pkg;

    localparam int   STR_MAX  = 32;
    localparam int   PAT_MAX  = 8;
    localparam int   DW       = 8;

    localparam logic KIND_STR = 1'b0;
    localparam logic KIND_PAT = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_STR,
        LOAD_PAT,
        SEND_STR,
        SEND_PAT,
        WAIT_RES
    } sme_feed_state_t;

endpackage

// File: rtl/sme_char_buf.sv
// Character buffer: sequential write with clear/commit, sequential replay from index 0.
module sme_char_buf #(
    parameter int DEPTH = 8,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          commit,
    input  logic          rd_first,
    input  logic          rd_next,
    output logic [DW-1:0] rd_data,
    output logic          rd_done,
    output logic          ovf_nxt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] wr_ptr_nxt;
    logic [CW-1:0] base;
    logic [CW-1:0] len;
    logic [CW-1:0] rd_ptr;
    logic          ovf;
    logic          room;
    logic          wr_hit;

    // A clear in the same cycle as a write restarts the frame at index 0.
    assign base       = clr ? '0 : wr_ptr;
    assign room       = (base < CW'(DEPTH));
    assign wr_hit     = wr_en && room;
    assign wr_ptr_nxt = wr_hit ? base + CW'(1) : base;
    assign ovf_nxt    = (ovf && !clr) || (wr_en && !room);
    assign rd_done    = (rd_ptr >= len);

    // Index 0 may be written on the very edge that starts replay, so bypass it.
    assign rd_data = rd_first ? ((wr_hit && base == '0) ? wr_data : mem[0])
                              : mem[rd_ptr[AW-1:0]];

    // NOTE: the storage array has no reset; wr_ptr/len carry validity and those do reset.
    always_ff @(posedge clk) begin
        if (wr_hit) mem[base[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            len    <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            ovf    <= ovf_nxt;
            if (commit)   len <= wr_ptr_nxt;
            else if (clr) len <= '0;
            if (rd_first)     rd_ptr <= CW'(1);
            else if (rd_next) rd_ptr <= rd_ptr + CW'(1);
        end
    end

endmodule

// File: rtl/sme_feeder.sv
// Buffers framed string/pattern bytes and replays them to the SME as one
// contiguous burst per match request, holding input off until the result.
module sme_feeder
    import sme_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_kind,
    input  logic          in_last,
    output logic [DW-1:0] chardata,
    output logic          isstring,
    output logic          ispattern,
    input  logic          sme_out_valid,
    output logic          busy,
    output logic          err
);

    sme_feed_state_t state, state_nxt;

    logic          beat, str_end, pat_end;
    logic          s_clr, s_wr, s_commit, s_rd_first, s_rd_next, s_done, s_ovf;
    logic          p_clr, p_wr, p_commit, p_rd_first, p_rd_next, p_done, p_ovf;
    logic [DW-1:0] s_rd_data, p_rd_data, chardata_nxt;
    logic          str_valid, str_dirty, dirty_set, dirty_clr;
    logic          emit_str, emit_pat, err_nxt;

    assign in_ready = rst_n && (state == IDLE || state == LOAD_STR || state == LOAD_PAT);
    assign busy     = (state == SEND_STR || state == SEND_PAT || state == WAIT_RES);
    assign beat     = in_valid && in_ready;

    sme_char_buf #(.DEPTH(STR_MAX), .DW(DW)) u_str_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (s_clr),
        .wr_en    (s_wr),
        .wr_data  (in_data),
        .commit   (s_commit),
        .rd_first (s_rd_first),
        .rd_next  (s_rd_next),
        .rd_data  (s_rd_data),
        .rd_done  (s_done),
        .ovf_nxt  (s_ovf)
    );

    sme_char_buf #(.DEPTH(PAT_MAX), .DW(DW)) u_pat_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (p_clr),
        .wr_en    (p_wr),
        .wr_data  (in_data),
        .commit   (p_commit),
        .rd_first (p_rd_first),
        .rd_next  (p_rd_next),
        .rd_data  (p_rd_data),
        .rd_done  (p_done),
        .ovf_nxt  (p_ovf)
    );

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            str_valid <= 1'b0;
            str_dirty <= 1'b0;
            chardata  <= '0;
            isstring  <= 1'b0;
            ispattern <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (s_commit)   str_valid <= 1'b1;
            else if (s_clr) str_valid <= 1'b0;
            if (dirty_set)      str_dirty <= 1'b1;
            else if (dirty_clr) str_dirty <= 1'b0;
            chardata  <= chardata_nxt;
            isstring  <= emit_str;
            ispattern <= emit_pat;
            err       <= err_nxt;
        end
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt  = state;
        str_end    = 1'b0;
        pat_end    = 1'b0;
        s_clr      = 1'b0;
        s_wr       = 1'b0;
        s_commit   = 1'b0;
        s_rd_first = 1'b0;
        s_rd_next  = 1'b0;
        p_clr      = 1'b0;
        p_wr       = 1'b0;
        p_commit   = 1'b0;
        p_rd_first = 1'b0;
        p_rd_next  = 1'b0;
        dirty_set  = 1'b0;
        dirty_clr  = 1'b0;
        emit_str   = 1'b0;
        emit_pat   = 1'b0;
        err_nxt    = 1'b0;

        unique case (state)
            IDLE: if (beat) begin
                if (in_kind == KIND_STR) begin
                    s_clr     = 1'b1;
                    s_wr      = 1'b1;
                    str_end   = in_last;
                    state_nxt = in_last ? IDLE : LOAD_STR;
                end else begin
                    p_clr     = 1'b1;
                    p_wr      = 1'b1;
                    pat_end   = in_last;
                    state_nxt = LOAD_PAT;
                end
            end
            LOAD_STR: if (beat) begin
                if (in_kind != KIND_STR) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    s_wr    = 1'b1;
                    str_end = in_last;
                    if (in_last) state_nxt = IDLE;
                end
            end
            LOAD_PAT: if (beat) begin
                if (in_kind != KIND_PAT) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    p_wr    = 1'b1;
                    pat_end = in_last;
                end
            end
            SEND_STR: begin
                if (!s_done) begin
                    s_rd_next = 1'b1;
                    emit_str  = 1'b1;
                end else begin
                    state_nxt  = SEND_PAT;
                    p_rd_first = 1'b1;
                    emit_pat   = 1'b1;
                end
            end
            SEND_PAT: begin
                if (!p_done) begin
                    p_rd_next = 1'b1;
                    emit_pat  = 1'b1;
                end else begin
                    state_nxt = WAIT_RES;
                    dirty_clr = 1'b1;
                end
            end
            WAIT_RES: if (sme_out_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (str_end) begin
            s_commit  = 1'b1;
            dirty_set = 1'b1;
            err_nxt   = s_ovf;
        end

        // A completed pattern starts replay at once; without a stored string it is dropped.
        if (pat_end) begin
            if (!str_valid) begin
                err_nxt   = 1'b1;
                state_nxt = IDLE;
            end else begin
                p_commit = 1'b1;
                err_nxt  = p_ovf;
                if (str_dirty) begin
                    state_nxt  = SEND_STR;
                    s_rd_first = 1'b1;
                    emit_str   = 1'b1;
                end else begin
                    state_nxt  = SEND_PAT;
                    p_rd_first = 1'b1;
                    emit_pat   = 1'b1;
                end
            end
        end
    end

    always_comb begin
        chardata_nxt = '0;
        if (emit_str)      chardata_nxt = s_rd_data;
        else if (emit_pat) chardata_nxt = p_rd_data;
    end

endmodule

// File: tb/tb_sme_feeder.sv
// Directed bench for sme_feeder: framing, replay order, reuse, overflow, aborts, reset.
module tb_sme_feeder;
    import sme_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_kind;
    logic          in_last;
    logic [DW-1:0] chardata;
    logic          isstring;
    logic          ispattern;
    logic          sme_out_valid;
    logic          busy;
    logic          err;

    always #5 clk = ~clk;

    sme_feeder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_kind       (in_kind),
        .in_last       (in_last),
        .chardata      (chardata),
        .isstring      (isstring),
        .ispattern     (ispattern),
        .sme_out_valid (sme_out_valid),
        .busy          (busy),
        .err           (err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Monitor state: written only by the negedge monitor.
    logic [9:0] seq_q[$];
    int         cyc_q[$];
    int         cyc = 0;
    int         err_cnt = 0;
    int         both_cnt = 0;
    int         stray_cnt = 0;
    int         overlap_cnt = 0;

    logic [7:0] exp_s[$];
    logic [7:0] exp_p[$];

    always @(negedge clk) begin
        cyc++;
        if (isstring || ispattern) begin
            seq_q.push_back({isstring, ispattern, chardata});
            cyc_q.push_back(cyc);
        end
        if (err) err_cnt++;
        if (isstring && ispattern) both_cnt++;
        if (!isstring && !ispattern && chardata != '0) stray_cnt++;
        if (busy && in_ready) overlap_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input logic k, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_kind  = k;
        in_last  = l;
        while (!in_ready && n < 64) begin
            step(1);
            n++;
        end
        check("beat_ready", in_ready, 1);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        in_data  = '0;
        in_kind  = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input string s, input logic k);
        for (int i = 0; i < s.len(); i++) send_beat(s[i], k, i == s.len() - 1);
    endtask

    task automatic pulse_result();
        sme_out_valid = 1'b1;
        step(1);
        sme_out_valid = 1'b0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        #1;
    endtask

    // Compares everything replayed since index base against exp_s then exp_p.
    task automatic expect_replay(input string tag, input int base);
        int ns = exp_s.size();
        int np = exp_p.size();
        check({tag, "_len"}, seq_q.size() - base, ns + np);
        for (int i = 0; i < ns + np; i++) begin
            logic [9:0] e;
            e = (i < ns) ? {2'b10, exp_s[i]} : {2'b01, exp_p[i - ns]};
            if (base + i < seq_q.size()) begin
                check($sformatf("%s_chr%0d", tag, i), seq_q[base + i], e);
                if (i > 0) check($sformatf("%s_gap%0d", tag, i),
                                 cyc_q[base + i] - cyc_q[base + i - 1], 1);
            end
        end
    endtask

    initial begin
        int b0;
        int e0;

        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_data       = '0;
        in_kind       = 1'b0;
        in_last       = 1'b0;
        sme_out_valid = 1'b0;
        step(3);
        check("rst_in_ready", in_ready, 0);
        check("rst_isstring", isstring, 0);
        check("rst_ispattern", ispattern, 0);
        check("rst_chardata", chardata, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", in_ready, 1);

        // 1: string "abc" + pattern "bc"
        b0 = seq_q.size();
        e0 = err_cnt;
        send_frame("abc", KIND_STR);
        check("t1_str_idle", busy, 0);
        send_frame("bc", KIND_PAT);
        check("t1_busy_start", busy, 1);
        check("t1_first_chr", {isstring, ispattern, chardata}, {2'b10, 8'h61});
        step(7);
        check("t1_busy_wait", busy, 1);
        check("t1_ready_wait", in_ready, 0);
        step(5);
        check("t1_busy_hold", busy, 1);
        exp_s = {8'h61, 8'h62, 8'h63};
        exp_p = {8'h62, 8'h63};
        expect_replay("t1", b0);
        pulse_result();
        check("t1_busy_done", busy, 0);
        check("t1_ready_done", in_ready, 1);
        check("t1_err", err_cnt - e0, 0);

        // 2: pattern-only "c" reuses the stored string
        b0 = seq_q.size();
        send_frame("c", KIND_PAT);
        step(4);
        check("t2_busy", busy, 1);
        exp_s.delete();
        exp_p = {8'h63};
        expect_replay("t2", b0);
        pulse_result();
        check("t2_idle", in_ready, 1);

        // 3: pattern without a string after reset
        reset_dut();
        b0 = seq_q.size();
        e0 = err_cnt;
        send_frame("x", KIND_PAT);
        step(3);
        check("t3_no_sme", seq_q.size() - b0, 0);
        check("t3_err_once", err_cnt - e0, 1);
        check("t3_busy", busy, 0);
        check("t3_ready", in_ready, 1);

        // 4: 35-byte string truncated to 32
        e0 = err_cnt;
        for (int i = 0; i < 35; i++) send_beat(8'h40 + 8'(i), KIND_STR, i == 34);
        step(3);
        check("t4_ovf_err", err_cnt - e0, 1);
        check("t4_idle", in_ready, 1);
        b0 = seq_q.size();
        send_frame("zz", KIND_PAT);
        step(40);
        exp_s.delete();
        for (int i = 0; i < 32; i++) exp_s.push_back(8'h40 + 8'(i));
        exp_p = {8'h7a, 8'h7a};
        expect_replay("t4", b0);
        check("t4_err_total", err_cnt - e0, 1);
        pulse_result();

        // 5: kind switches mid string frame
        e0 = err_cnt;
        b0 = seq_q.size();
        send_beat(8'h70, KIND_STR, 1'b0);
        send_beat(8'h71, KIND_PAT, 1'b0);
        step(2);
        check("t5_abort_err", err_cnt - e0, 1);
        check("t5_ready", in_ready, 1);
        check("t5_busy", busy, 0);
        send_frame("k", KIND_PAT);
        step(3);
        check("t5_pat_err", err_cnt - e0, 2);
        check("t5_no_sme", seq_q.size() - b0, 0);
        check("t5_busy2", busy, 0);

        // 6: reset during string replay
        send_frame("mnop", KIND_STR);
        send_frame("n", KIND_PAT);
        check("t6_replaying", {isstring, chardata}, {1'b1, 8'h6d});
        rst_n = 1'b0;
        step(1);
        check("t6_isstring", isstring, 0);
        check("t6_ispattern", ispattern, 0);
        check("t6_chardata", chardata, 0);
        check("t6_busy", busy, 0);
        check("t6_ready_rst", in_ready, 0);
        rst_n = 1'b1;
        #1;
        check("t6_ready_rel", in_ready, 1);
        b0 = seq_q.size();
        e0 = err_cnt;
        pulse_result();
        check("t6_ovalid_idle_ready", in_ready, 1);
        check("t6_ovalid_idle_busy", busy, 0);
        send_frame("n", KIND_PAT);
        step(3);
        check("t6_buf_invalid", err_cnt - e0, 1);
        check("t6_no_sme", seq_q.size() - b0, 0);

        check("never_both", both_cnt, 0);
        check("idle_chardata_zero", stray_cnt, 0);
        check("ready_busy_exclusive", overlap_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
